// File: rtl/nco_phase_tracker.sv
// nco_phase_tracker: sequential CORDIC phase recovery from I/Q samples with windowed frequency estimate.
// Optional lock detector is compiled in when NCO_TRACK_LOCK_EN is defined.
module nco_phase_tracker #(
    parameter int ITER     = 6,
    parameter int LOG2_WIN = 4,
    parameter int LOCK_TOL = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] sine_bits,
    input  logic [4:0] cosine_bits,
    output logic [7:0] phase_out,
    output logic       phase_valid,
    output logic [7:0] freq_word,
    output logic       freq_valid,
    output logic       locked
);
    localparam int AW = 8 + LOG2_WIN;
    localparam int CW = LOG2_WIN + 1;
    localparam logic [CW-1:0] WIN = CW'(1 << LOG2_WIN);
    localparam logic [7:0] ATAN [6] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1};
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
    state_t state_q, state_d;
    logic signed [9:0] x_q, x_d, y_q, y_d, xs, ys, xi, qi;
    logic [7:0] z_q, z_d, prev_q, prev_d, phase_q, phase_d, freq_q, freq_d, atan, delta;
    logic [2:0] i_q, i_d;
    logic [AW-1:0] acc_q, acc_d, acc_sum;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic have_prev_q, have_prev_d, pv_q, pv_d, fv_q, fv_d, take, win_done;

    assign in_ready    = (state_q == IDLE);
    assign phase_out   = phase_q;
    assign phase_valid = pv_q;
    assign freq_word   = freq_q;
    assign freq_valid  = fv_q;

    always_comb begin
        xi = {{2{cosine_bits[4]}}, cosine_bits, 3'b000};
        qi = {{2{sine_bits[4]}}, sine_bits, 3'b000};
        xs = x_q >>> i_q;
        ys = y_q >>> i_q;
        atan = ATAN[i_q];
        delta = z_q - prev_q;
        acc_sum = acc_q + AW'(delta);
        cnt_inc = cnt_q + CW'(1);
        take = clk_en && (state_q == DONE) && have_prev_q;
        win_done = take && (cnt_inc == WIN);
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        i_d = i_q;
        prev_d = prev_q;
        have_prev_d = have_prev_q;
        phase_d = phase_q;
        freq_d = freq_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        pv_d = clk_en && (state_q == DONE);
        fv_d = win_done;
        // Left-half-plane inputs are rotated by pi so the vectoring loop always converges
        if (clk_en && state_q == IDLE && in_valid) begin
            x_d = cosine_bits[4] ? -xi : xi;
            y_d = cosine_bits[4] ? -qi : qi;
            z_d = cosine_bits[4] ? 8'd128 : 8'd0;
            i_d = '0;
            state_d = ROT;
        end
        if (clk_en && state_q == ROT) begin
            x_d = y_q[9] ? x_q - ys : x_q + ys;
            y_d = y_q[9] ? y_q + xs : y_q - xs;
            z_d = y_q[9] ? z_q - atan : z_q + atan;
            i_d = i_q + 3'd1;
            state_d = (i_q == 3'(ITER - 1)) ? DONE : ROT;
        end
        if (clk_en && state_q == DONE) begin
            phase_d = z_q;
            prev_d = z_q;
            have_prev_d = 1'b1;
            state_d = IDLE;
        end
        if (take) begin
            acc_d = win_done ? '0 : acc_sum;
            cnt_d = win_done ? '0 : cnt_inc;
            freq_d = win_done ? acc_sum[LOG2_WIN +: 8] : freq_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            i_q <= '0;
            prev_q <= '0;
            have_prev_q <= 1'b0;
            phase_q <= '0;
            freq_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            pv_q <= 1'b0;
            fv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            i_q <= i_d;
            prev_q <= prev_d;
            have_prev_q <= have_prev_d;
            phase_q <= phase_d;
            freq_q <= freq_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            pv_q <= pv_d;
            fv_q <= fv_d;
        end
    end

`ifdef NCO_TRACK_LOCK_EN
    localparam logic signed [7:0] TOL = 8'(LOCK_TOL);
    logic locked_q, locked_d, have_est_q, have_est_d, ok_q, ok_d, ok_now;
    logic signed [7:0] dist;

    assign locked = locked_q;

    // Wrapped difference against the previous estimate; the window flag restarts on its first delta
    always_comb begin
        dist = delta - freq_q;
        ok_now = ((cnt_q == '0) || ok_q) && (dist >= -TOL) && (dist <= TOL);
        ok_d = take ? ok_now : ok_q;
        locked_d = win_done ? (have_est_q && ok_now) : locked_q;
        have_est_d = have_est_q || win_done;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            have_est_q <= 1'b0;
            ok_q <= 1'b1;
        end else begin
            locked_q <= locked_d;
            have_est_q <= have_est_d;
            ok_q <= ok_d;
        end
    end
`else
    assign locked = 1'b0;
`endif
endmodule

// File: tb/tb_nco_phase_tracker.sv
// tb_nco_phase_tracker: randomized bench for nco_phase_tracker against a behavioural phase/frequency model.
module tb_nco_phase_tracker;
    localparam int ITER = 6;
    localparam int LOG2_WIN = 4;
    localparam int LOCK_TOL = 2;
    localparam int WIN = 1 << LOG2_WIN;
`ifdef NCO_TRACK_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clk_en = 1'b0;
    logic in_valid = 1'b0;
    logic [4:0] sine_bits = '0;
    logic [4:0] cosine_bits = '0;
    logic in_ready, phase_valid, freq_valid, locked;
    logic [7:0] phase_out, freq_word;

    int n_checks = 0;
    int n_pass = 0;
    int have_prev_m, prev_m, freq_m, have_est_m, locked_m, fv_m;
    int win_q[$];
    int nco_ph = 0;

    nco_phase_tracker #(.ITER(ITER), .LOG2_WIN(LOG2_WIN), .LOCK_TOL(LOCK_TOL)) dut (
        .clock(clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(in_ready),
        .sine_bits(sine_bits), .cosine_bits(cosine_bits), .phase_out(phase_out),
        .phase_valid(phase_valid), .freq_word(freq_word), .freq_valid(freq_valid), .locked(locked)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        n_checks++;
        if (d <= tol && d >= -tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    endtask

    function automatic int sdist(input int a, input int b);
        return ((a - b + 128) & 255) - 128;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Vectoring CORDIC on plain integers: drives the vector onto the +x axis and sums the angles used
    function automatic int cordic(input int i, input int q);
        int x, y, z, t;
        int a[6] = '{32, 19, 10, 5, 3, 1};
        x = i * 8;
        y = q * 8;
        z = 0;
        if (i < 0) begin
            x = -x;
            y = -y;
            z = 128;
        end
        for (int k = 0; k < ITER; k++) begin
            t = x;
            if (y >= 0) begin
                x = x + (y >>> k);
                y = y - (t >>> k);
                z = z + a[k];
            end else begin
                x = x - (y >>> k);
                y = y + (t >>> k);
                z = z - a[k];
            end
        end
        return z & 255;
    endfunction

    task automatic model_reset();
        have_prev_m = 0;
        prev_m = 0;
        freq_m = 0;
        have_est_m = 0;
        locked_m = 0;
        fv_m = 0;
        win_q.delete();
    endtask

    task automatic model_step(input int ph);
        int sum, ok;
        fv_m = 0;
        if (have_prev_m != 0) begin
            win_q.push_back((ph - prev_m) & 255);
            if (win_q.size() == WIN) begin
                sum = 0;
                ok = 1;
                foreach (win_q[k]) begin
                    sum += win_q[k];
                    if (sdist(win_q[k], freq_m) > LOCK_TOL || sdist(win_q[k], freq_m) < -LOCK_TOL) ok = 0;
                end
                locked_m = (LOCK_ON && have_est_m != 0 && ok != 0) ? 1 : 0;
                freq_m = (sum >> LOG2_WIN) & 255;
                have_est_m = 1;
                fv_m = 1;
                win_q.delete();
            end
        end
        prev_m = ph;
        have_prev_m = 1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, in_ready, 1, 0);
        check({tag, "_phase"}, phase_out, 0, 0);
        check({tag, "_pv"}, phase_valid, 0, 0);
        check({tag, "_freq"}, freq_word, 0, 0);
        check({tag, "_fv"}, freq_valid, 0, 0);
        check({tag, "_lock"}, locked, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        clk_en = 1'b1;
        model_reset();
    endtask

    task automatic do_sample(input int i, input int q, input int stall, output int ph, output int fv);
        int n;
        clk_en = 1'b1;
        cosine_bits = 5'(i);
        sine_bits = 5'(q);
        in_valid = 1'b1;
        check("accept_rdy", in_ready, 1, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("busy_rdy", in_ready, 0, 0);
        cosine_bits = 5'($urandom);
        sine_bits = 5'($urandom);
        n = 0;
        while (n < 40) begin
            clk_en = (n >= 2 && n < 2 + stall) ? 1'b0 : 1'b1;
            @(posedge clock);
            #1;
            n++;
            if (phase_valid) break;
        end
        clk_en = 1'b1;
        model_step(cordic(i, q));
        check("latency", n, ITER + 1 + stall, 0);
        check("phase", phase_out, prev_m, 0);
        check("fv", freq_valid, fv_m, 0);
        check("freq", freq_word, freq_m, 0);
        check("locked", locked, locked_m, 0);
        ph = phase_out;
        fv = freq_valid;
        clk_en = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
        check("pv_clear", phase_valid, 0, 0);
        check("fv_clear", freq_valid, 0, 0);
        clk_en = 1'b1;
    endtask

    task automatic run_nco(input int inc, input int count, output int first_fv, output int nfv);
        int i, q, ph, fv;
        real ang;
        first_fv = -1;
        nfv = 0;
        for (int k = 0; k < count; k++) begin
            ang = 6.283185307179586 * nco_ph / 256.0;
            i = rnd(15.0 * $cos(ang));
            q = rnd(15.0 * $sin(ang));
            do_sample(i, q, 0, ph, fv);
            if (fv != 0) begin
                nfv++;
                if (first_fv < 0) first_fv = k;
            end
            nco_ph = (nco_ph + inc) & 255;
        end
    endtask

    task automatic run_rand(input int count, input int max_stall, output int first_fv, output int nfv);
        int ph, fv;
        first_fv = -1;
        nfv = 0;
        for (int k = 0; k < count; k++) begin
            do_sample($urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, $urandom_range(0, max_stall), ph, fv);
            if (fv != 0) begin
                nfv++;
                if (first_fv < 0) first_fv = k;
            end
        end
    endtask

    task automatic backpressure();
        int last, run, nacc, npv, rdy;
        cosine_bits = 5'd9;
        sine_bits = 5'(-7);
        in_valid = 1'b1;
        last = -1;
        run = 0;
        nacc = 0;
        npv = 0;
        for (int c = 0; c < 34; c++) begin
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (phase_valid) begin
                npv++;
                check("bp_phase", phase_out, cordic(9, -7), 0);
            end
            if (rdy != 0) begin
                if (last >= 0) begin
                    check("bp_gap", c - last, ITER + 2, 0);
                    check("bp_low", run, ITER + 1, 0);
                end
                last = c;
                run = 0;
                nacc++;
            end else run++;
        end
        in_valid = 1'b0;
        check("bp_accepts", nacc, 5, 0);
        check("bp_pulses", npv, 4, 0);
    endtask

    initial begin
        int ph, fv, first_fv, nfv;
        int card_i[4] = '{15, 0, -15, 0};
        int card_q[4] = '{0, 15, 0, -15};
        #1;
        check_reset_vals("init");
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_sample(card_i[k], card_q[k], 0, ph, fv);
            check("cardinal", sdist(ph, 64 * k), 0, 2);
        end
        do_reset();
        backpressure();
        do_reset();
        run_nco(16, 17, first_fv, nfv);
        check("f16_first_fv", first_fv, 16, 0);
        check("f16_nfv", nfv, 1, 0);
        check("f16_word", freq_word, 16, 1);
        check("f16_unlocked", locked, 0, 0);
        run_nco(16, 16, first_fv, nfv);
        check("f16b_first_fv", first_fv, 15, 0);
        run_nco(200, 32, first_fv, nfv);
        check("f200_nfv", nfv, 2, 0);
        check("f200_word", freq_word, 200, 1);
        run_nco(40, 32, first_fv, nfv);
        check("f40_nfv", nfv, 2, 0);
        check("f40_word", freq_word, 40, 1);
        check("f40_unlocked", locked, 0, 0);
        for (int k = 0; k < 3; k++) begin
            do_sample($urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, 5, ph, fv);
        end
        run_rand(8, 0, first_fv, nfv);
        cosine_bits = 5'd11;
        sine_bits = 5'd3;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        run_rand(17, 0, first_fv, nfv);
        check("rst_first_fv", first_fv, 16, 0);
        check("rst_nfv", nfv, 1, 0);
        run_rand(40, 3, first_fv, nfv);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
